// File: rtl/strand_suspend_controller_pkg.sv
// Shared constants for the strand suspend/resume sequencer.
package strand_suspend_controller_pkg;

  localparam int NUM_STRANDS_DEF = 4;
  localparam int STRAND_ID_W_DEF = 2;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_READY = 2'd2;

  localparam logic [31:0] COUNT_SAT = 32'hFFFF_FFFF;

endpackage

// File: rtl/strand_suspend_controller_rr_arbiter.sv
// Combinational round-robin pick: first requester strictly after pointer, wrapping.
module rr_arbiter #(
  parameter int WIDTH = 4,
  parameter int ID_W  = 2
) (
  input  logic [WIDTH-1:0] request,
  input  logic [ID_W-1:0]  pointer,
  output logic             grant_valid,
  output logic [ID_W-1:0]  grant_index
);

  logic [ID_W-1:0] cand;

  // WIDTH is a power of two, so ID_W-bit addition wraps naturally.
  always_comb begin
    grant_valid = 1'b0;
    grant_index = '0;
    cand        = '0;
    for (int k = 1; k <= WIDTH; k++) begin
      cand = pointer + ID_W'(k);
      if (!grant_valid && request[cand]) begin
        grant_valid = 1'b1;
        grant_index = cand;
      end
    end
  end

endmodule

// File: rtl/strand_suspend_controller.sv
// Per-strand park/wake/resume sequencing with round-robin release,
// suspended-cycle accounting and a sticky protocol-error flag.
//
//   state | meaning
//   RUN   | strand issuing, strand_enable high
//   WAIT  | parked, waiting for dcache/store-buffer wake
//   READY | woken, requesting release from the arbiter
module strand_suspend_controller
  import strand_suspend_controller_pkg::*;
#(
  parameter int NUM_STRANDS = NUM_STRANDS_DEF,
  parameter int STRAND_ID_W = STRAND_ID_W_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [STRAND_ID_W-1:0] wb_strand,
  input  logic                   wb_rollback_request,
  input  logic                   wb_suspend_request,
  input  logic                   wb_retry,
  input  logic [NUM_STRANDS-1:0] dcache_resume_strands,
  input  logic [NUM_STRANDS-1:0] stbuf_resume_strands,
  output logic [NUM_STRANDS-1:0] strand_enable,
  output logic                   resume_valid,
  output logic [STRAND_ID_W-1:0] resume_strand,
  output logic [31:0]            suspended_cycle_count,
  output logic                   protocol_error
);

  logic [1:0]             state_q [NUM_STRANDS];
  logic [1:0]             state_d [NUM_STRANDS];
  logic [NUM_STRANDS-1:0] wake;
  logic [NUM_STRANDS-1:0] request;
  logic [NUM_STRANDS-1:0] enable_q;
  logic [STRAND_ID_W-1:0] pointer_q;
  logic [STRAND_ID_W-1:0] resume_strand_q;
  logic                   resume_valid_q;
  logic                   error_q;
  logic [31:0]            count_q;
  logic [31:0]            count_d;
  logic [32:0]            count_sum;
  logic [STRAND_ID_W:0]   not_run;
  logic                   park;
  logic                   park_ok;
  logic                   error_now;
  logic                   grant_valid;
  logic [STRAND_ID_W-1:0] grant_index;

  assign wake = dcache_resume_strands | stbuf_resume_strands;
  assign park = wb_suspend_request & wb_rollback_request & ~wb_retry;

  always_comb begin
    park_ok   = park && (state_q[wb_strand] == ST_RUN);
    error_now = (wb_suspend_request && !wb_rollback_request)
             || (wb_suspend_request && wb_retry)
             || (park && (state_q[wb_strand] != ST_RUN));
  end

  always_comb begin
    request = '0;
    not_run = '0;
    for (int i = 0; i < NUM_STRANDS; i++) begin
      request[i] = (state_q[i] == ST_READY);
      if (state_q[i] != ST_RUN) not_run = not_run + 1'b1;
    end
  end

  rr_arbiter #(
    .WIDTH (NUM_STRANDS),
    .ID_W  (STRAND_ID_W)
  ) u_rr_arbiter (
    .request     (request),
    .pointer     (pointer_q),
    .grant_valid (grant_valid),
    .grant_index (grant_index)
  );

  // A wake arriving with the park goes straight to READY so it is not lost.
  always_comb begin
    for (int i = 0; i < NUM_STRANDS; i++) begin
      state_d[i] = state_q[i];
      case (state_q[i])
        ST_RUN: begin
          if (park_ok && (wb_strand == STRAND_ID_W'(i)))
            state_d[i] = wake[i] ? ST_READY : ST_WAIT;
        end
        ST_WAIT: begin
          if (wake[i]) state_d[i] = ST_READY;
        end
        ST_READY: begin
          if (grant_valid && (grant_index == STRAND_ID_W'(i))) state_d[i] = ST_RUN;
        end
        default: state_d[i] = ST_RUN;
      endcase
    end
  end

  always_comb begin
    count_sum = {1'b0, count_q} + {{(32 - STRAND_ID_W){1'b0}}, not_run};
    count_d   = count_sum[32] ? COUNT_SAT : count_sum[31:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_STRANDS; i++) state_q[i] <= ST_RUN;
      enable_q        <= '1;
      pointer_q       <= STRAND_ID_W'(NUM_STRANDS - 1);
      resume_valid_q  <= 1'b0;
      resume_strand_q <= '0;
      error_q         <= 1'b0;
      count_q         <= '0;
    end else begin
      for (int i = 0; i < NUM_STRANDS; i++) begin
        state_q[i]  <= state_d[i];
        enable_q[i] <= (state_d[i] == ST_RUN);
      end
      resume_valid_q <= grant_valid;
      if (grant_valid) begin
        pointer_q       <= grant_index;
        resume_strand_q <= grant_index;
      end
      if (error_now) error_q <= 1'b1;
      count_q <= count_d;
    end
  end

  assign strand_enable         = enable_q;
  assign resume_valid          = resume_valid_q;
  assign resume_strand         = resume_strand_q;
  assign suspended_cycle_count = count_q;
  assign protocol_error        = error_q;

endmodule

// File: tb/tb_strand_suspend_controller.sv
// Directed bench for strand_suspend_controller: park/wake/release ordering,
// protocol errors, counter saturation and asynchronous reset.
module tb_strand_suspend_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  wb_strand;
  logic        wb_rollback_request;
  logic        wb_suspend_request;
  logic        wb_retry;
  logic [3:0]  dcache_resume_strands;
  logic [3:0]  stbuf_resume_strands;
  logic [3:0]  strand_enable;
  logic        resume_valid;
  logic [1:0]  resume_strand;
  logic [31:0] suspended_cycle_count;
  logic        protocol_error;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  strand_suspend_controller dut (
    .clk                   (clk),
    .reset                 (reset),
    .wb_strand             (wb_strand),
    .wb_rollback_request   (wb_rollback_request),
    .wb_suspend_request    (wb_suspend_request),
    .wb_retry              (wb_retry),
    .dcache_resume_strands (dcache_resume_strands),
    .stbuf_resume_strands  (stbuf_resume_strands),
    .strand_enable         (strand_enable),
    .resume_valid          (resume_valid),
    .resume_strand         (resume_strand),
    .suspended_cycle_count (suspended_cycle_count),
    .protocol_error        (protocol_error)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    wb_strand             = 2'd0;
    wb_rollback_request   = 1'b0;
    wb_suspend_request    = 1'b0;
    wb_retry              = 1'b0;
    dcache_resume_strands = 4'b0000;
    stbuf_resume_strands  = 4'b0000;
  endtask

  // Inputs change just after a falling edge; outputs are sampled on the next one.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic park(input logic [1:0] s, input logic [3:0] dwake);
    wb_strand             = s;
    wb_rollback_request   = 1'b1;
    wb_suspend_request    = 1'b1;
    dcache_resume_strands = dwake;
    tick();
    idle_inputs();
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();
    #12;

    // 1: reset then idle
    do_reset();
    repeat (10) tick();
    chk("t1_enable", 32'(strand_enable), 32'h0000000F);
    chk("t1_valid", 32'(resume_valid), 32'h0);
    chk("t1_count", suspended_cycle_count, 32'h0);
    chk("t1_error", 32'(protocol_error), 32'h0);

    // 2: park strand 2, wake five edges later
    park(2'd2, 4'b0000);
    chk("t2_enable_e0", 32'(strand_enable), 32'h0000000B);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk($sformatf("t2_enable_e%0d", k), 32'(strand_enable), 32'h0000000B);
    end
    dcache_resume_strands = 4'b0100;
    tick();
    idle_inputs();
    chk("t2_enable_e5", 32'(strand_enable), 32'h0000000B);
    chk("t2_valid_e5", 32'(resume_valid), 32'h0);
    tick();
    chk("t2_valid_e6", 32'(resume_valid), 32'h1);
    chk("t2_strand_e6", 32'(resume_strand), 32'h2);
    chk("t2_enable_e6", 32'(strand_enable), 32'h0000000F);
    chk("t2_count_e6", suspended_cycle_count, 32'd6);
    tick();
    chk("t2_valid_e7", 32'(resume_valid), 32'h0);
    chk("t2_strand_hold", 32'(resume_strand), 32'h2);
    chk("t2_count_e7", suspended_cycle_count, 32'd6);

    // 3: park and wake strand 1 in the same cycle
    park(2'd1, 4'b0010);
    chk("t3_enable", 32'(strand_enable), 32'h0000000D);
    chk("t3_valid0", 32'(resume_valid), 32'h0);
    tick();
    chk("t3_valid1", 32'(resume_valid), 32'h1);
    chk("t3_strand", 32'(resume_strand), 32'h1);
    chk("t3_enable1", 32'(strand_enable), 32'h0000000F);
    chk("t3_count", suspended_cycle_count, 32'd7);

    // 4: round-robin ordering from pointer 3
    do_reset();
    park(2'd0, 4'b0000);
    park(2'd1, 4'b0000);
    park(2'd3, 4'b0000);
    chk("t4_enable_parked", 32'(strand_enable), 32'h00000004);
    chk("t4_count_parked", suspended_cycle_count, 32'd3);
    dcache_resume_strands = 4'b1011;
    tick();
    idle_inputs();
    chk("t4_valid_wake", 32'(resume_valid), 32'h0);
    chk("t4_count_wake", suspended_cycle_count, 32'd6);
    tick();
    chk("t4_g0_valid", 32'(resume_valid), 32'h1);
    chk("t4_g0_strand", 32'(resume_strand), 32'h0);
    chk("t4_g0_enable", 32'(strand_enable), 32'h00000005);
    tick();
    chk("t4_g1_strand", 32'(resume_strand), 32'h1);
    chk("t4_g1_enable", 32'(strand_enable), 32'h00000007);
    tick();
    chk("t4_g3_valid", 32'(resume_valid), 32'h1);
    chk("t4_g3_strand", 32'(resume_strand), 32'h3);
    chk("t4_g3_enable", 32'(strand_enable), 32'h0000000F);
    chk("t4_g3_count", suspended_cycle_count, 32'd12);
    tick();
    chk("t4_idle_valid", 32'(resume_valid), 32'h0);
    // move pointer to 1, then wake 0 and 3 together
    park(2'd1, 4'b0010);
    tick();
    chk("t4_p1_strand", 32'(resume_strand), 32'h1);
    park(2'd0, 4'b0000);
    park(2'd3, 4'b0000);
    stbuf_resume_strands = 4'b1001;
    tick();
    idle_inputs();
    tick();
    chk("t4_wrap_first", 32'(resume_strand), 32'h3);
    chk("t4_wrap_first_v", 32'(resume_valid), 32'h1);
    tick();
    chk("t4_wrap_second", 32'(resume_strand), 32'h0);
    tick();
    chk("t4_wrap_done_v", 32'(resume_valid), 32'h0);
    chk("t4_wrap_enable", 32'(strand_enable), 32'h0000000F);

    // 5: protocol errors
    do_reset();
    wb_strand = 2'd2;
    wb_suspend_request = 1'b1;
    tick();
    idle_inputs();
    chk("t5_norb_error", 32'(protocol_error), 32'h1);
    chk("t5_norb_enable", 32'(strand_enable), 32'h0000000F);
    repeat (3) tick();
    chk("t5_sticky", 32'(protocol_error), 32'h1);
    chk("t5_sticky_count", suspended_cycle_count, 32'h0);

    do_reset();
    wb_strand = 2'd1;
    wb_suspend_request = 1'b1;
    wb_rollback_request = 1'b1;
    wb_retry = 1'b1;
    tick();
    idle_inputs();
    chk("t5_retry_error", 32'(protocol_error), 32'h1);
    chk("t5_retry_enable", 32'(strand_enable), 32'h0000000F);

    do_reset();
    wb_strand = 2'd3;
    wb_rollback_request = 1'b1;
    wb_retry = 1'b1;
    tick();
    idle_inputs();
    chk("t5_retry_only_err", 32'(protocol_error), 32'h0);
    chk("t5_retry_only_en", 32'(strand_enable), 32'h0000000F);
    park(2'd0, 4'b0000);
    chk("t5_park1_err", 32'(protocol_error), 32'h0);
    chk("t5_park1_en", 32'(strand_enable), 32'h0000000E);
    park(2'd0, 4'b0000);
    chk("t5_park2_err", 32'(protocol_error), 32'h1);
    chk("t5_park2_en", 32'(strand_enable), 32'h0000000E);
    tick();
    chk("t5_still_wait", 32'(strand_enable), 32'h0000000E);
    chk("t5_no_release", 32'(resume_valid), 32'h0);
    dcache_resume_strands = 4'b0001;
    tick();
    idle_inputs();
    tick();
    chk("t5_release_v", 32'(resume_valid), 32'h1);
    chk("t5_release_s", 32'(resume_strand), 32'h0);

    // 6: counter saturation, then asynchronous reset mid-suspension
    do_reset();
    park(2'd3, 4'b1000);
    tick();
    chk("t6_pre_strand", 32'(resume_strand), 32'h3);
    park(2'd2, 4'b0000);
    wb_suspend_request = 1'b1;
    tick();
    idle_inputs();
    chk("t6_pre_error", 32'(protocol_error), 32'h1);
    force dut.count_q = 32'hFFFF_FFFD;
    #1;
    release dut.count_q;
    tick();
    chk("t6_count_fe", suspended_cycle_count, 32'hFFFF_FFFE);
    tick();
    chk("t6_count_ff", suspended_cycle_count, 32'hFFFF_FFFF);
    tick();
    chk("t6_count_hold", suspended_cycle_count, 32'hFFFF_FFFF);
    chk("t6_enable_susp", 32'(strand_enable), 32'h0000000B);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_async_enable", 32'(strand_enable), 32'h0000000F);
    chk("t6_async_valid", 32'(resume_valid), 32'h0);
    chk("t6_async_strand", 32'(resume_strand), 32'h0);
    chk("t6_async_count", suspended_cycle_count, 32'h0);
    chk("t6_async_error", 32'(protocol_error), 32'h0);
    tick();
    reset = 1'b1;
    dcache_resume_strands = 4'b0100;
    tick();
    idle_inputs();
    tick();
    chk("t6_wake_dropped_v", 32'(resume_valid), 32'h0);
    chk("t6_wake_dropped_en", 32'(strand_enable), 32'h0000000F);
    chk("t6_wake_dropped_c", suspended_cycle_count, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
